// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the
// instruction-memory fetch controller.
package imem_pkg;
  localparam int INSTR_W    = 16;
  localparam int IMEM_AW    = 4;
  localparam int IMEM_DEPTH = 15;
  localparam int IMEM_PC_W  = 16;
  localparam int PC_STEP    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Loader, memory and core-side signals of the
// fetch controller, bundled with modports.
interface imem_fetch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int AW     = 4
) ();
  logic              start;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              running;
  logic              halted;
  logic              load_err;

  modport slave (
    input  start, load_valid, load_data,
    input  load_last, mem_rdata, stall,
    input  redirect_valid, redirect_pc,
    output load_ready, mem_we, mem_addr,
    output mem_wdata, pc, instr, instr_valid,
    output running, halted, load_err
  );

  modport master (
    output start, load_valid, load_data,
    output load_last, mem_rdata, stall,
    output redirect_valid, redirect_pc,
    input  load_ready, mem_we, mem_addr,
    input  mem_wdata, pc, instr, instr_valid,
    input  running, halted, load_err
  );
endinterface

// File: rtl/imem_pc_gen.sv
// PC register with redirect/stall/increment
// next-PC selection and fetch range check.
module imem_pc_gen
  import imem_pkg::*;
#(
  parameter int PC_W  = IMEM_PC_W,
  parameter int AW    = IMEM_AW,
  parameter int DEPTH = IMEM_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            pc_init,
  input  logic            redirect_valid,
  input  logic [PC_W-2:0] redirect_tgt,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [AW-1:0]   idx,
  output logic            in_range
);
  logic [PC_W-1:0] pc_q, pc_d;

  assign pc  = pc_q;
  assign idx = pc_q[AW:1];
  assign in_range =
    ({1'b0, idx} < (AW+1)'(DEPTH)) &&
    (pc_q[PC_W-1:AW+1] == '0);

  // an out-of-range fetch freezes pc for HALT
  always_comb begin
    pc_d = pc_q;
    if (pc_init)
      pc_d = RESET_PC;
    else if (run && redirect_valid)
      pc_d = {redirect_tgt, 1'b0};
    else if (run && in_range && !stall)
      pc_d = pc_q + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory controller: streams a program
// into memory, then fetches for the core.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int PC_W   = IMEM_PC_W,
  parameter int AW     = IMEM_AW,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  imem_fetch_ctrl_if.slave bus
);
  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          pc_init, hs, run;
  logic          in_range;
  logic [AW-1:0] pc_idx;
  logic          unused_rpc0;

  assign unused_rpc0 = bus.redirect_pc[0];
  assign run = (state_q == ST_RUN);
  assign hs  = (state_q == ST_LOAD) &&
               bus.load_valid;

  imem_pc_gen #(
    .PC_W     (PC_W),
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .pc_init        (pc_init),
    .redirect_valid (bus.redirect_valid),
    .redirect_tgt   (bus.redirect_pc[PC_W-1:1]),
    .stall          (bus.stall),
    .pc             (bus.pc),
    .idx            (pc_idx),
    .in_range       (in_range)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    pc_init = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.load_valid) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end else if (bus.start) begin
          state_d = ST_RUN;
          pc_init = 1'b1;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          ptr_d = ptr_q + 1'b1;
          // last slot without load_last is overflow
          if (bus.load_last ||
              ptr_q == AW'(DEPTH-1)) begin
            state_d = ST_RUN;
            pc_init = 1'b1;
            ptr_d   = '0;
            err_d   = err_q | ~bus.load_last;
          end
        end
      end
      ST_RUN: begin
        if (!in_range && !bus.redirect_valid)
          state_d = ST_HALT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.mem_we      = hs;
  assign bus.mem_addr    = (state_q == ST_LOAD) ?
                           ptr_q : pc_idx;
  assign bus.mem_wdata   = hs ? bus.load_data : '0;
  assign bus.instr_valid = run && in_range;
  assign bus.instr       = bus.instr_valid ?
                           bus.mem_rdata : '0;
  assign bus.running     = run;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.load_err    = err_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench: memory array, behavioural
// model compared every cycle, plus directed checks.
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 15;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(
    .DATA_W(16), .PC_W(16), .AW(4)
  ) bus ();

  imem_fetch_ctrl #(
    .DATA_W(16), .PC_W(16), .AW(4),
    .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] ram [16];
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk)
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  always @(posedge clk)
    if (bus.mem_we) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // behavioural model
  int m_mode, m_ptr, m_pc;
  bit m_err;
  logic [15:0] m_mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE;
      m_pc   <= 0;
      m_ptr  <= 0;
      m_err  <= 1'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_HALT: begin
          if (bus.load_valid) begin
            m_mode <= M_LOAD;
            m_ptr  <= 0;
          end else if (bus.start) begin
            m_mode <= M_RUN;
            m_pc   <= 0;
          end
        end
        M_LOAD: if (bus.load_valid) begin
          m_mem[m_ptr] <= bus.load_data;
          if (bus.load_last) begin
            m_mode <= M_RUN; m_pc <= 0; m_ptr <= 0;
          end else if (m_ptr == DEPTH-1) begin
            m_mode <= M_RUN; m_pc <= 0; m_ptr <= 0;
            m_err  <= 1'b1;
          end else begin
            m_ptr <= m_ptr + 1;
          end
        end
        default: begin
          if (bus.redirect_valid)
            m_pc <= int'(bus.redirect_pc) & 'hFFFE;
          else if (m_pc / 2 >= DEPTH)
            m_mode <= M_HALT;
          else if (!bus.stall)
            m_pc <= (m_pc + 2) % 65536;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pc", 32'(bus.pc), m_pc);
      chk("running", 32'(bus.running),
          32'(m_mode == M_RUN));
      chk("halted", 32'(bus.halted),
          32'(m_mode == M_HALT));
      chk("load_err", 32'(bus.load_err),
          32'(m_err));
      chk("load_ready", 32'(bus.load_ready),
          32'(m_mode == M_LOAD));
      chk("mem_we", 32'(bus.mem_we),
          32'(m_mode == M_LOAD && bus.load_valid));
      chk("mem_addr", 32'(bus.mem_addr),
          (m_mode == M_LOAD) ? m_ptr
                             : (m_pc / 2) % 16);
      if (m_mode == M_LOAD && bus.load_valid)
        chk("mem_wdata", 32'(bus.mem_wdata),
            32'(bus.load_data));
      chk("instr_valid", 32'(bus.instr_valid),
          32'(m_mode == M_RUN && m_pc / 2 < DEPTH));
      chk("instr", 32'(bus.instr),
          (m_mode == M_RUN && m_pc / 2 < DEPTH) ?
          32'(m_mem[(m_pc / 2) % 16]) : 32'h0);
    end
  end

  task automatic drv(input logic lv,
                     input logic [15:0] d,
                     input logic last,
                     input logic st,
                     input logic stl,
                     input logic rv,
                     input logic [15:0] rp);
    bus.load_valid     = lv;
    bus.load_data      = d;
    bus.load_last      = last;
    bus.start          = st;
    bus.stall          = stl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_prog(input int n,
                           input logic [15:0] base,
                           input logic [15:0] step,
                           input bit use_last);
    int i = 0;
    int g = 0;
    logic hs;
    while (i < n && g < 64) begin
      drv(1, base + 16'(i) * step,
          use_last && (i == n - 1), 0, 0, 0, 16'h0);
      #1;
      hs = bus.load_ready;
      tick();
      if (hs) i++;
      g++;
    end
    chk("load_words", i, n);
    idle();
  endtask

  task automatic run_to(input logic [15:0] tgt);
    int g = 0;
    while (bus.pc != tgt && g < 40) begin
      tick();
      g++;
    end
    chk("reach_pc", 32'(bus.pc), 32'(tgt));
  endtask

  int wr0;

  initial begin
    for (int k = 0; k < 16; k++) begin
      ram[k]   = 16'h0;
      m_mem[k] = 16'h0;
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_ready", 32'(bus.load_ready), 32'h0);
    chk("rst_instr", 32'(bus.instr), 32'h0);
    rst_n = 1'b1;

    // reset in the middle of a load
    drv(1, 16'h0A00, 0, 0, 0, 0, 16'h0);
    tick();
    for (int j = 0; j < 3; j++) begin
      drv(1, 16'h0A00 + 16'(j), 0, 0, 0, 0, 16'h0);
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_we", 32'(bus.mem_we), 32'h0);
    chk("async_ready", 32'(bus.load_ready), 32'h0);
    chk("async_pc", 32'(bus.pc), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(1, 16'h0B00, 0, 0, 0, 0, 16'h0);
    tick();
    chk("reload_we", 32'(bus.mem_we), 32'h1);
    chk("reload_addr", 32'(bus.mem_addr), 32'h0);
    do_reset();

    // normal 5-word load then fetch
    wr0 = wr_cnt;
    load_prog(5, 16'h1111, 16'h1111, 1);
    chk("n_writes5", wr_cnt - wr0, 5);
    chk("run_after5", 32'(bus.running), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk("seq_pc", 32'(bus.pc), 2 * k);
      chk("seq_instr", 32'(bus.instr),
          32'h1111 * (k + 1));
      tick();
    end

    // stall then redirect overriding stall
    drv(0, 16'h0, 0, 0, 0, 1, 16'h0004);
    tick();
    drv(0, 16'h0, 0, 0, 1, 0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_pc", 32'(bus.pc), 32'h4);
      tick();
    end
    drv(0, 16'h0, 0, 0, 1, 1, 16'h0007);
    tick();
    chk("redir_pc", 32'(bus.pc), 32'h6);
    chk("redir_instr", 32'(bus.instr), 32'h4444);
    idle();

    // overflow load
    do_reset();
    wr0 = wr_cnt;
    load_prog(15, 16'hA000, 16'h0001, 0);
    drv(1, 16'hA00F, 0, 0, 0, 0, 16'h0);
    #1;
    chk("ovf_ready16", 32'(bus.load_ready), 32'h0);
    chk("ovf_writes", wr_cnt - wr0, 15);
    chk("ovf_err", 32'(bus.load_err), 32'h1);
    chk("ovf_run", 32'(bus.running), 32'h1);
    tick();
    idle();

    // run off the end, redirect rescues once
    run_to(16'h001E);
    chk("end_valid", 32'(bus.instr_valid), 32'h0);
    chk("end_instr", 32'(bus.instr), 32'h0);
    drv(0, 16'h0, 0, 0, 0, 1, 16'h0001);
    tick();
    chk("rescue_pc", 32'(bus.pc), 32'h0);
    chk("rescue_run", 32'(bus.running), 32'h1);
    idle();
    run_to(16'h001C);
    chk("last_instr", 32'(bus.instr), 32'hA00E);
    run_to(16'h001E);
    tick();
    chk("halted", 32'(bus.halted), 32'h1);
    chk("halt_pc", 32'(bus.pc), 32'h1E);
    drv(0, 16'h0, 0, 1, 0, 0, 16'h0);
    tick();
    chk("restart_run", 32'(bus.running), 32'h1);
    chk("restart_pc", 32'(bus.pc), 32'h0);
    idle();
    run_to(16'h001E);
    tick();
    chk("halted2", 32'(bus.halted), 32'h1);
    drv(1, 16'hBEEF, 0, 0, 0, 0, 16'h0);
    tick();
    chk("halt_to_load", 32'(bus.load_ready), 32'h1);
    drv(0, 16'h0, 0, 1, 0, 0, 16'h0);
    tick();
    chk("load_ign_start", 32'(bus.load_ready), 32'h1);
    drv(1, 16'hBEEF, 1, 0, 0, 0, 16'h0);
    tick();
    idle();
    chk("reload_run", 32'(bus.running), 32'h1);
    chk("err_sticky", 32'(bus.load_err), 32'h1);
    chk("reload_instr", 32'(bus.instr), 32'hBEEF);

    // IDLE priority: load beats start
    do_reset();
    drv(1, 16'h1234, 0, 1, 0, 0, 16'h0);
    tick();
    idle();
    chk("prio_load", 32'(bus.load_ready), 32'h1);
    chk("prio_norun", 32'(bus.running), 32'h0);
    do_reset();
    drv(0, 16'h0, 0, 1, 0, 0, 16'h0);
    tick();
    idle();
    chk("start_run", 32'(bus.running), 32'h1);
    chk("start_pc", 32'(bus.pc), 32'h0);
    chk("start_instr", 32'(bus.instr), 32'hBEEF);
    chk("start_err", 32'(bus.load_err), 32'h0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Owns the single-port instruction memory, a 16-bit word array of depth DEPTH that is read combinationally.
- Sequences two phases:
  - LOAD: a program is streamed into memory word by word over a valid/ready port.
  - RUN: the controller holds the PC, drives the byte-addressed fetch (word index = pc[4:1]) and handles stall and redirect from the core.
- Sits between the boot/debug loader, the instruction memory array and the core's decode stage.

Parameters:
- DATA_W, 16, instruction/word width
- PC_W, 16, program counter width
- AW, 4, memory word-address width (word index = pc[AW:1])
- DEPTH, 15, number of valid memory words (must be <= 2**AW)
- RESET_PC, 16'h0000, PC value on entering RUN (bit 0 must be 0)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  IDLE only: begin RUN without loading
- load_valid  in  1  loader word present
- load_ready  out  1  controller accepts loader word
- load_data  in  DATA_W  word to write
- load_last  in  1  final word of program, qualified by load_valid
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data
- stall  in  1  core holds current fetch
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  PC_W  branch/jump target
- pc  out  PC_W  current fetch PC
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr is a valid fetch
- running  out  1  state == RUN
- halted  out  1  state == HALT
- load_err  out  1  sticky: program overflowed DEPTH

Behaviour:

States: IDLE, LOAD, RUN, HALT; 2-bit encoding in the package.

Reset (async, rst_n=0):
- State goes to IDLE; pc=RESET_PC; load_ptr=0; load_err=0.
- All outputs 0 except pc.
- Reset mid-LOAD abandons the partial program with no further writes. Memory contents are not cleared.

IDLE:
- load_ready=0.
- start=1 goes to RUN with pc=RESET_PC.
- load_valid=1 goes to LOAD with load_ptr=0.
- If both are asserted, load_valid wins.

LOAD:
- load_ready=1 combinationally.
- A handshake (load_valid & load_ready) drives mem_we=1, mem_addr=load_ptr, mem_wdata=load_data in the same cycle; load_ptr increments.
- Exit to RUN (pc=RESET_PC, load_ptr=0) when either:
  - the accepted word has load_last=1, or
  - the word written is at load_ptr==DEPTH-1 with load_last=0. In this case load_err is also set to 1 (sticky until reset), and later words are not accepted.
- No handshake in a cycle: no write, no state change.
- start is ignored.

RUN:
- mem_we=0; mem_addr=pc[AW:1]; instr=mem_rdata; instr_valid=1 when pc[AW:1] < DEPTH.
- PC update each clock, in priority order:
  1. redirect_valid=1: pc <= {redirect_pc[PC_W-1:1],1'b0}. Redirect overrides stall. Odd targets are forced even.
  2. stall=1: pc holds.
  3. Otherwise pc <= pc+2, wrapping modulo 2**PC_W.
- Fetch index out of range:
  - Condition: pc[AW:1] >= DEPTH or pc[PC_W-1:AW+1] != 0.
  - Response: instr_valid=0 and instr=0 combinationally; next clock goes to HALT, unless redirect_valid=1 in that cycle, which redirects and stays in RUN.
- load_valid is ignored; load_ready=0.

HALT:
- instr_valid=0; pc holds.
- load_valid=1 goes to LOAD (reload, load_ptr=0, load_err holds).
- start=1 returns to RUN with pc=RESET_PC. load_valid has priority.

Timing:
- Fetch latency is 0 cycles: instr reflects pc in the same cycle.
- PC changes only on clk edges.
- mem_addr mux: load_ptr in LOAD, otherwise pc[AW:1].

Decomposition:
- Shared package imem_pkg:
  - state encoding constants (ST_IDLE, ST_LOAD, ST_RUN, ST_HALT)
  - INSTR_W=16, IMEM_AW=4, IMEM_DEPTH=15, PC_STEP=2
- Keep the same values as the existing global `col`/`row_i` defines.
- One natural sub-module, imem_pc_gen: the PC register plus the redirect/stall/increment next-PC mux and the range check. The FSM and loader pointer stay in imem_fetch_ctrl.

Test Plan:
1. Reset mid-load:
   - Stimulus: assert rst_n=0 after 3 accepted words.
   - Required: state IDLE, load_ptr 0, pc 0x0000, mem_we 0 immediately (async). Next load restarts writing at address 0.
2. Normal load and fetch:
   - Stimulus: stream 5 words 0x1111..0x5555, load_last on the 5th.
   - Required: mem_we pulses at addresses 0..4; running=1 on the next cycle.
   - Then with stall=0, pc goes 0,2,4,6,8 and instr 0x1111..0x5555, instr_valid=1.
3. Stall vs redirect:
   - Stimulus: at pc=4, hold stall=1 for 3 cycles; then stall=1 with redirect_valid=1 and redirect_pc=0x0007.
   - Required: pc stays 4 for 3 cycles, then becomes 0x0006.
4. Overflow load:
   - Stimulus: 16 words with load_last never set.
   - Required: exactly 15 writes (addresses 0..14); load_err=1; RUN entered after the 15th write; the 16th word sees load_ready=0.
5. Run off end:
   - Stimulus: after a 15-word program, free-run.
   - Required: at pc=0x001E, instr_valid=0 and instr=0; halted=1 on the next cycle.
   - Then load_valid goes to LOAD; start goes to RUN with pc=0.
6. IDLE priority:
   - Stimulus: start=1 and load_valid=1 in the same cycle.
   - Required: enters LOAD, not RUN.
   - Separately, start alone enters RUN executing the existing memory contents from pc 0.
